// File: rtl/seq_code_lock.sv
// Keypad combination lock: buffers a full code entry, compares on ENTER, auto-relocks, reprogrammable while open.
// Optional LOCKOUT state after MAX_FAIL wrong attempts is built only when SEQ_LOCK_LOCKOUT_EN is defined.
`timescale 1ns/1ps
module seq_code_lock #(
    parameter int                            CODE_LEN       = 6,
    parameter int                            SYMBOL_W       = 1,
    parameter logic [CODE_LEN*SYMBOL_W-1:0]  DEFAULT_CODE   = 6'b101011,
    parameter int                            MAX_FAIL       = 3,
    parameter int                            OPEN_CYCLES    = 500,
    parameter int                            LOCKOUT_CYCLES = 1000
) (
    input  logic                              hz100,
    input  logic                              rst_n,
    input  logic                              key_valid,
    input  logic [SYMBOL_W-1:0]               key_data,
    input  logic                              key_enter,
    input  logic                              key_clear,
    input  logic                              key_prog,
    output logic                              unlocked,
    output logic                              alarm,
    output logic [2:0]                        state,
    output logic [$clog2(CODE_LEN+2)-1:0]     digit_cnt,
    output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);
    localparam int CW   = CODE_LEN * SYMBOL_W;
    localparam int DW   = $clog2(CODE_LEN + 2);
    localparam int FW   = $clog2(MAX_FAIL + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [2:0] LOCKED  = 3'd0;
    localparam logic [2:0] ENTRY   = 3'd1;
    localparam logic [2:0] OPEN    = 3'd2;
    localparam logic [2:0] PROGRAM = 3'd3;

    localparam logic [DW-1:0] DIG_FULL  = DW'(CODE_LEN);
    localparam logic [DW-1:0] DIG_OVF   = DW'(CODE_LEN + 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAIL);
    localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);
`ifdef SEQ_LOCK_LOCKOUT_EN
    localparam logic [2:0]    LOCKOUT   = 3'd4;
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);
`endif

    logic [CW-1:0] entry_buf, buf_n;
    logic [CW-1:0] code, code_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    state_n;
    logic [DW-1:0] digit_n;
    logic [FW-1:0] fail_n;
    logic          capture, wrong, match;

    assign match = (digit_cnt == DIG_FULL) && (entry_buf == code);

    always_comb begin
        state_n = state;
        digit_n = digit_cnt;
        fail_n  = fail_cnt;
        buf_n   = entry_buf;
        code_n  = code;
        timer_n = timer;
        capture = 1'b0;
        wrong   = 1'b0;
        // Priority within each state: clear > enter > valid > prog
        case (state)
            LOCKED: begin
                if (key_clear) begin
                    digit_n = '0;
                end else if (key_enter) begin
                    digit_n = '0;
                    wrong   = 1'b1;
                end else if (key_valid) begin
                    capture = 1'b1;
                    state_n = ENTRY;
                end
            end
            ENTRY: begin
                if (key_clear) begin
                    state_n = LOCKED;
                    digit_n = '0;
                end else if (key_enter) begin
                    digit_n = '0;
                    if (match) begin
                        state_n = OPEN;
                        fail_n  = '0;
                        timer_n = '0;
                    end else begin
                        state_n = LOCKED;
                        wrong   = 1'b1;
                    end
                end else if (key_valid) begin
                    capture = 1'b1;
                end
            end
            OPEN: begin
                if (key_clear) begin
                    state_n = LOCKED;
                    digit_n = '0;
                    timer_n = '0;
                end else if (key_enter || key_valid) begin
                    timer_n = '0;
                end else if (key_prog) begin
                    state_n = PROGRAM;
                    digit_n = '0;
                    timer_n = '0;
                end else if (timer == OPEN_LAST) begin
                    state_n = LOCKED;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            PROGRAM: begin
                if (key_clear) begin
                    state_n = OPEN;
                    digit_n = '0;
                    timer_n = '0;
                end else if (key_enter) begin
                    digit_n = '0;
                    timer_n = '0;
                    if (digit_cnt == DIG_FULL) begin
                        code_n  = entry_buf;
                        state_n = LOCKED;
                    end else begin
                        state_n = OPEN;
                    end
                end else if (key_valid) begin
                    capture = 1'b1;
                end
            end
`ifdef SEQ_LOCK_LOCKOUT_EN
            LOCKOUT: begin
                if (timer == LOCK_LAST) begin
                    state_n = LOCKED;
                    fail_n  = '0;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
`endif
            default: begin
                state_n = LOCKED;
                digit_n = '0;
                timer_n = '0;
            end
        endcase

        if (capture) begin
            buf_n = CW'({entry_buf, key_data});
            if (digit_cnt != DIG_OVF) digit_n = digit_cnt + 1'b1;
        end

        if (wrong) begin
            if (fail_cnt != FAIL_MAX) fail_n = fail_cnt + 1'b1;
`ifdef SEQ_LOCK_LOCKOUT_EN
            if (fail_n == FAIL_MAX) begin
                state_n = LOCKOUT;
                timer_n = '0;
            end
`endif
        end
    end

    always_ff @(posedge hz100 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOCKED;
            unlocked  <= 1'b0;
            alarm     <= 1'b0;
            digit_cnt <= '0;
            fail_cnt  <= '0;
            entry_buf <= '0;
            code      <= DEFAULT_CODE;
            timer     <= '0;
        end else begin
            state     <= state_n;
            unlocked  <= (state_n == OPEN) || (state_n == PROGRAM);
`ifdef SEQ_LOCK_LOCKOUT_EN
            alarm     <= (state_n == LOCKOUT);
`else
            alarm     <= 1'b0;
`endif
            digit_cnt <= digit_n;
            fail_cnt  <= fail_n;
            entry_buf <= buf_n;
            code      <= code_n;
            timer     <= timer_n;
        end
    end
endmodule
